// File: rtl/sincos_pipe_if.sv
// Stream + coefficient-table bus for the sin/cos pipeline.
// master drives samples, back-pressure and table writes; slave is the pipeline.
interface sincos_pipe_if #(
  parameter int IN_W   = 16,
  parameter int ADDR_W = 7,
  parameter int C0_W   = 19,
  parameter int C1_W   = 12,
  parameter int OUT_W  = 16,
  parameter int TAG_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_phase;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_sin;
  logic [OUT_W-1:0]  out_cos;
  logic [TAG_W-1:0]  out_tag;
  logic              tbl_we;
  logic [ADDR_W-1:0] tbl_addr;
  logic [C0_W-1:0]   tbl_c0;
  logic [C1_W-1:0]   tbl_c1;

  modport master (
    output in_valid, in_phase, in_tag, out_ready, tbl_we, tbl_addr, tbl_c0, tbl_c1,
    input  in_ready, out_valid, out_sin, out_cos, out_tag
  );

  modport slave (
    input  in_valid, in_phase, in_tag, out_ready, tbl_we, tbl_addr, tbl_c0, tbl_c1,
    output in_ready, out_valid, out_sin, out_cos, out_tag
  );
endinterface

// File: rtl/sincos_pipe.sv
// Four-stage sin/cos generator: quadrant fold, shared {c0,c1} table lookup,
// linear interpolation, then sign/round/saturate. Lane 0 is cos, lane 1 is sin.

// One output lane: S3 interpolation and S4 sign/round/saturate.
module sincos_lane #(
  parameter int C0_W  = 19,
  parameter int C1_W  = 12,
  parameter int X_W   = 7,
  parameter int Y_W   = C0_W + X_W + 1,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic [C0_W-1:0]  c0_i,
  input  logic [C1_W-1:0]  c1_i,
  input  logic [X_W-1:0]   x_i,
  input  logic             neg_i,
  output logic [OUT_W-1:0] res_o
);
  localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};

  logic [Y_W-1:0]   base, slope, y_d, y_q, ys;
  logic             neg_q, rbit, sat;
  logic [OUT_W-1:0] top, res_d, res_q;
  logic             unused_lo;

  // S3: walk down from the segment start by c1*x, floored at zero
  always_comb begin
    base  = {1'b0, c0_i, {X_W{1'b0}}};
    slope = Y_W'(c1_i) * Y_W'(x_i);
    y_d   = (base >= slope) ? base - slope : '0;
  end

  // S3 register
  always_ff @(posedge clk) begin
    if (adv_i) begin
      y_q   <= y_d;
      neg_q <= neg_i;
    end
  end

  // S4: apply sign, round half up, clamp the one positive overflow case
  always_comb begin
    ys    = neg_q ? -y_q : y_q;
    top   = ys[Y_W-1 -: OUT_W];
    rbit  = ys[Y_W-1-OUT_W];
    // only a positive full-scale value can carry out when rounded
    sat   = (top == POS_MAX) & rbit;
    res_d = sat ? POS_MAX : top + OUT_W'(rbit);
  end

  assign unused_lo = ^ys[Y_W-2-OUT_W:0];

  // S4 register, cleared on reset
  always_ff @(posedge clk) begin
    if (!rst_n)     res_q <= '0;
    else if (adv_i) res_q <= res_d;
  end

  assign res_o = res_q;
endmodule

module sincos_pipe #(
  parameter int IN_W   = 16,
  parameter int ADDR_W = 7,
  parameter int C0_W   = 19,
  parameter int C1_W   = 12,
  parameter int OUT_W  = 16,
  parameter int TAG_W  = 4
) (
  input logic           clk,
  input logic           rst_n,
  sincos_pipe_if.slave  bus
);
  localparam int X_W       = IN_W - 2 - ADDR_W;
  localparam int Y_W       = C0_W + X_W + 1;
  localparam int IDX_W     = IN_W - 2;
  localparam int STAGES    = 4;
  localparam int NUM_LANES = 2;

  logic                                  adv;
  logic [STAGES:1]                       vld_pipe_q;
  logic [STAGES:1][TAG_W-1:0]            tag_q;
  logic [1:0]                            quad, quad1_q, quad2_q;
  logic [IDX_W-1:0]                      idx;
  logic [NUM_LANES-1:0][IDX_W-1:0]       fold;
  logic [NUM_LANES-1:0][ADDR_W-1:0]      addr_d, addr_q;
  logic [NUM_LANES-1:0][X_W-1:0]         x_d, x1_q, x2_q;
  logic [NUM_LANES-1:0][C0_W-1:0]        c0_q;
  logic [NUM_LANES-1:0][C1_W-1:0]        c1_q;
  logic [NUM_LANES-1:0]                  neg;
  logic [NUM_LANES-1:0][OUT_W-1:0]       res;
  logic [C0_W+C1_W-1:0]                  tbl_mem [2**ADDR_W];

  // Whole pipe moves together whenever the output slot is free or draining.
  assign adv          = ~vld_pipe_q[STAGES] | bus.out_ready;
  assign bus.in_ready = adv;

  // S1: fold the phase into the first quadrant for each lane
  always_comb begin
    quad    = bus.in_phase[IN_W-1 -: 2];
    idx     = bus.in_phase[IDX_W-1:0];
    fold[0] = quad[0] ? ~idx : idx;
    fold[1] = quad[0] ? idx : ~idx;
    for (int l = 0; l < NUM_LANES; l++) begin
      addr_d[l] = fold[l][IDX_W-1 -: ADDR_W];
      x_d[l]    = fold[l][X_W-1:0];
    end
  end

  // Valid and tag shift registers; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      tag_q      <= '0;
    end else if (adv) begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], bus.in_valid};
      tag_q      <= {tag_q[STAGES-1:1], bus.in_tag};
    end
  end

  // S1/S2 data registers; S2 reads the table for both lanes
  always_ff @(posedge clk) begin
    if (adv) begin
      addr_q  <= addr_d;
      x1_q    <= x_d;
      quad1_q <= quad;
      x2_q    <= x1_q;
      quad2_q <= quad1_q;
      for (int l = 0; l < NUM_LANES; l++)
        {c0_q[l], c1_q[l]} <= tbl_mem[addr_q[l]];
    end
  end

  // Table write; a read of the same entry on this edge still sees old data
  always_ff @(posedge clk) begin
    if (bus.tbl_we) tbl_mem[bus.tbl_addr] <= {bus.tbl_c0, bus.tbl_c1};
  end

  // cos is negative in quadrants 1,2; sin in quadrants 2,3
  assign neg[0] = quad2_q[1] ^ quad2_q[0];
  assign neg[1] = quad2_q[1];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sincos_lane #(
      .C0_W (C0_W),
      .C1_W (C1_W),
      .X_W  (X_W),
      .Y_W  (Y_W),
      .OUT_W(OUT_W)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .adv_i(adv),
      .c0_i (c0_q[g]),
      .c1_i (c1_q[g]),
      .x_i  (x2_q[g]),
      .neg_i(neg[g]),
      .res_o(res[g])
    );
  end

  assign bus.out_valid = vld_pipe_q[STAGES];
  assign bus.out_cos   = res[0];
  assign bus.out_sin   = res[1];
  assign bus.out_tag   = tag_q[STAGES];
endmodule
